// File: rtl/alu_op_issuer_if.sv
// Host request handshake plus the registered ALU drive pins of the operand-issue stage.
interface alu_op_issuer_if #(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4
);
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [M-1:0] req_cmd;
  logic [N-1:0] req_opa;
  logic [N-1:0] req_opb;
  logic         req_cin;
  logic         req_split;
  logic [4:0]   req_gap;

  logic         ce;
  logic [1:0]   inp_valid;
  logic         mode;
  logic [M-1:0] cmd;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic         cin;
  logic         sample_strobe;
  logic         busy;
  logic [7:0]   op_count;

  modport master (
    output req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split, req_gap,
    input  req_ready, ce, inp_valid, mode, cmd, opa, opb, cin, sample_strobe, busy, op_count
  );

  modport slave (
    input  req_valid, req_mode, req_cmd, req_opa, req_opb, req_cin, req_split, req_gap,
    output req_ready, ce, inp_valid, mode, cmd, opa, opb, cin, sample_strobe, busy, op_count
  );
endinterface

// File: rtl/alu_op_issuer.sv
// ALU operand-issue stage: request FIFO feeding an FSM that drives the ALU pins, either
// together or as split phase A / gap / phase B delivery, then strobes when results are stable.
module alu_op_issuer #(
  parameter int unsigned N           = 8,
  parameter int unsigned M           = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned RESULT_WAIT = 2
) (
  input logic           clk,
  input logic           reset,
  alu_op_issuer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] WaitLoad = 3'(RESULT_WAIT - 1);

  typedef struct packed {
    logic         mode;
    logic [M-1:0] cmd;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic         cin;
    logic [4:0]   gap;
  } op_t;

  typedef struct packed {
    logic split;
    op_t  op;
  } entry_t;

  typedef enum logic [2:0] {StIdle, StIssue, StPhaseA, StGap, StPhaseB, StWait} state_e;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          ready_en_q;
  logic          empty, full, push, pop;
  entry_t        head, wr_entry;
  op_t           cur_q;

  state_e        state_q, state_d;
  logic [4:0]    gap_cnt_q;
  logic [2:0]    wait_cnt_q;

  logic          ce_q, ce_d;
  logic [1:0]    iv_q, iv_d;
  logic          mode_q, mode_d;
  logic [M-1:0]  cmd_q, cmd_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic          cin_q, cin_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    count_q, count_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // ready_en_q keeps req_ready low until the first edge after reset deasserts.
  assign bus.req_ready = ready_en_q && !full;
  assign push  = bus.req_valid && bus.req_ready;
  assign pop   = (state_q == StIdle) && !empty;
  assign head  = mem[rd_ptr_q[AW-1:0]];

  assign wr_entry = '{split: bus.req_split,
                      op: '{mode: bus.req_mode, cmd: bus.req_cmd, opa: bus.req_opa,
                            opb: bus.req_opb, cin: bus.req_cin, gap: bus.req_gap}};

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_en_q <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset)    cur_q <= '0;
    else if (pop) cur_q <= head.op;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      if (state_q == StPhaseA)  gap_cnt_q <= cur_q.gap - 5'd1;
      else if (state_q == StGap) gap_cnt_q <= gap_cnt_q - 5'd1;
      if (state_q == StIssue || state_q == StPhaseB) wait_cnt_q <= WaitLoad;
      else if (state_q == StWait)                     wait_cnt_q <= wait_cnt_q - 3'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!empty) state_d = head.split ? StPhaseA : StIssue;
      StIssue:  state_d = StWait;
      StPhaseA: state_d = (cur_q.gap != 5'd0) ? StGap : StPhaseB;
      StGap:    if (gap_cnt_q == 5'd0) state_d = StPhaseB;
      StPhaseB: state_d = StWait;
      StWait:   if (wait_cnt_q == 3'd0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Drive is registered from the current state, so pins lag the FSM by one cycle.
  always_comb begin
    ce_d     = 1'b0;
    iv_d     = iv_q;
    mode_d   = mode_q;
    cmd_d    = cmd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    strobe_d = (state_q == StWait) && (wait_cnt_q == 3'd0);
    count_d  = count_q + {7'd0, strobe_d};
    unique case (state_q)
      StIssue: begin
        ce_d   = 1'b1;
        iv_d   = 2'b11;
        mode_d = cur_q.mode;
        cmd_d  = cur_q.cmd;
        opa_d  = cur_q.opa;
        opb_d  = cur_q.opb;
        cin_d  = cur_q.cin;
      end
      StPhaseA, StGap: begin
        ce_d   = 1'b1;
        iv_d   = 2'b01;
        mode_d = cur_q.mode;
        cmd_d  = cur_q.cmd;
        opa_d  = cur_q.opa;
        opb_d  = '0;
        cin_d  = cur_q.cin;
      end
      StPhaseB: begin
        ce_d   = 1'b1;
        iv_d   = 2'b10;
        mode_d = cur_q.mode;
        cmd_d  = cur_q.cmd;
        opa_d  = cur_q.opa;
        opb_d  = cur_q.opb;
        cin_d  = cur_q.cin;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_q     <= 1'b0;
      iv_q     <= 2'b00;
      mode_q   <= 1'b0;
      cmd_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      strobe_q <= 1'b0;
      count_q  <= '0;
    end else begin
      ce_q     <= ce_d;
      iv_q     <= iv_d;
      mode_q   <= mode_d;
      cmd_q    <= cmd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      strobe_q <= strobe_d;
      count_q  <= count_d;
    end
  end

  assign bus.ce            = ce_q;
  assign bus.inp_valid     = iv_q;
  assign bus.mode          = mode_q;
  assign bus.cmd           = cmd_q;
  assign bus.opa           = opa_q;
  assign bus.opb           = opb_q;
  assign bus.cin           = cin_q;
  assign bus.sample_strobe = strobe_q;
  assign bus.op_count      = count_q;
  assign bus.busy          = (state_q != StIdle) || !empty;
endmodule

// File: tb/tb_alu_op_issuer.sv
// Scoreboard bench for alu_op_issuer: expected operations are queued on accept and compared
// against operations reconstructed from the ALU pins at each sample strobe.
module tb_alu_op_issuer;
  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.N(8), .M(4)) bus ();

  alu_op_issuer #(.N(8), .M(4), .DEPTH(4), .RESULT_WAIT(RW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       cin;
    logic       split;
    logic [4:0] gap;
    logic [3:0] sdelay;
    logic       bad;
    logic [7:0] cnt;
  } rec_t;

  rec_t       exp_q[$];
  rec_t       obs_q[$];
  logic [7:0] exp_count;
  int         checks;
  int         failures;

  // Monitor: rebuilds each operation from the pins, sampled on the falling edge.
  int         mon_cyc;
  int         a_cnt;
  int         last_ce;
  logic [7:0] a_opa;
  logic       a_bad;
  rec_t       pend;

  initial begin
    mon_cyc = 0; a_cnt = 0; last_ce = 0; a_opa = '0; a_bad = 1'b0; pend = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        a_cnt = 0;
        a_bad = 1'b0;
      end else begin
        if (bus.ce && bus.inp_valid == 2'b01) begin
          if (a_cnt == 0) a_opa = bus.opa;
          else if (bus.opa !== a_opa) a_bad = 1'b1;
          if (bus.opb !== 8'h00) a_bad = 1'b1;
          a_cnt++;
          last_ce = mon_cyc;
        end else if (bus.ce && (bus.inp_valid == 2'b11 || bus.inp_valid == 2'b10)) begin
          pend.mode  = bus.mode;
          pend.cmd   = bus.cmd;
          pend.opa   = bus.opa;
          pend.opb   = bus.opb;
          pend.cin   = bus.cin;
          pend.split = (bus.inp_valid == 2'b10);
          if (bus.inp_valid == 2'b10) begin
            pend.gap = 5'(a_cnt - 1);
            pend.bad = a_bad || (a_cnt == 0) || (bus.opa !== a_opa);
          end else begin
            pend.gap = 5'd0;
            pend.bad = (a_cnt != 0);
          end
          a_cnt   = 0;
          a_bad   = 1'b0;
          last_ce = mon_cyc;
        end
        if (bus.sample_strobe) begin
          pend.sdelay = 4'(mon_cyc - last_ce);
          pend.cnt    = bus.op_count;
          obs_q.push_back(pend);
        end
      end
      mon_cyc++;
    end
  end

  task automatic send(input logic mode, input logic [3:0] cmd, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, input logic split,
                      input logic [4:0] gap);
    int   w;
    rec_t e;
    bus.req_valid = 1'b1;
    bus.req_mode  = mode;
    bus.req_cmd   = cmd;
    bus.req_opa   = a;
    bus.req_opb   = b;
    bus.req_cin   = cin;
    bus.req_split = split;
    bus.req_gap   = gap;
    w = 0;
    while (!bus.req_ready && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (!bus.req_ready) begin
      failures++;
      $display("FAIL send_accept req_ready=%b after %0d cycles, required 1", bus.req_ready, w);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_count = exp_count + 8'd1;
    e.mode   = mode;
    e.cmd    = cmd;
    e.opa    = a;
    e.opb    = b;
    e.cin    = cin;
    e.split  = split;
    e.gap    = split ? gap : 5'd0;
    e.sdelay = 4'(RW);
    e.bad    = 1'b0;
    e.cnt    = exp_count;
    exp_q.push_back(e);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
    ok = (obs_q.size() >= n);
  endtask

  function automatic logic [35:0] all_outs();
    return {bus.ce, bus.inp_valid, bus.mode, bus.cmd, bus.opa, bus.opb, bus.cin,
            bus.sample_strobe, bus.busy, bus.op_count, bus.req_ready};
  endfunction

  task automatic test_reset();
    logic [35:0] v;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_mode = 1'b0; bus.req_cmd = '0; bus.req_opa = '0;
    bus.req_opb = '0; bus.req_cin = 1'b0; bus.req_split = 1'b0; bus.req_gap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    v = all_outs();
    checks++;
    if (v !== 36'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", v);
    end
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete(); obs_q.delete(); exp_count = 8'd0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early got=%b want=0", bus.req_ready);
    end
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_ready_after got ready,busy=%b want=10", {bus.req_ready, bus.busy});
    end
  endtask

  task automatic test_single();
    bit   ok;
    rec_t o, e;
    send(1'b1, 4'd0, 8'h0F, 8'h01, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.ce} !== 2'b10) begin
      failures++;
      $display("FAIL single_accept_cycle busy,ce=%b want=10", {bus.busy, bus.ce});
    end
    @(negedge clk);
    checks++;
    if (bus.ce !== 1'b0) begin
      failures++;
      $display("FAIL single_pop_cycle ce=%b want=0", bus.ce);
    end
    @(negedge clk);
    checks++;
    if ({bus.ce, bus.inp_valid, bus.opa, bus.opb} !== {3'b111, 8'h0F, 8'h01}) begin
      failures++;
      $display("FAIL single_drive got=%h want=%h", {bus.ce, bus.inp_valid, bus.opa, bus.opb},
               {3'b111, 8'h0F, 8'h01});
    end
    @(negedge clk);
    checks++;
    if ({bus.ce, bus.sample_strobe} !== 2'b00) begin
      failures++;
      $display("FAIL single_wait ce,strobe=%b want=00", {bus.ce, bus.sample_strobe});
    end
    @(negedge clk);
    checks++;
    if ({bus.sample_strobe, bus.op_count} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL single_strobe strobe,count=%h want=%h", {bus.sample_strobe, bus.op_count},
               {1'b1, 8'd1});
    end
    wait_obs(1, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_timeout ops=%0d want=1", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL single_op got=%h want=%h", o, e);
      end
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_split(input logic [4:0] gap, input logic [7:0] a, input logic [7:0] b);
    bit   ok;
    rec_t o, e;
    send(1'b0, 4'd1, a, b, 1'b1, 1'b1, gap);
    wait_obs(1, 200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL split_timeout gap=%0d ops=%0d want=1", gap, obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL split_op gap=%0d got=%h want=%h", gap, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    rec_t o, e;
    // A long split op keeps the FSM busy so the queue fills.
    send(1'b0, 4'd2, 8'h11, 8'h22, 1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 4; i++)
      send(1'b1, 4'(i + 3), 8'(8'h30 + i), 8'(8'h40 + i), 1'(i), 1'b0, 5'd0);
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_full_ready got=%b want=0", bus.req_ready);
    end
    send(1'b1, 4'd7, 8'h34, 8'h44, 1'b0, 1'b0, 5'd0);
    wait_obs(6, 300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL b2b_timeout ops=%0d want=6", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_op got=%h want=%h", o, e);
      end
    end
    checks++;
    if (bus.op_count !== exp_count) begin
      failures++;
      $display("FAIL b2b_count got=%0d want=%0d", bus.op_count, exp_count);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] v;
    int          w;
    send(1'b1, 4'd5, 8'h33, 8'h66, 1'b0, 1'b1, 5'd15);
    send(1'b1, 4'd6, 8'h01, 8'h02, 1'b0, 1'b0, 5'd0);
    send(1'b1, 4'd6, 8'h03, 8'h04, 1'b0, 1'b0, 5'd0);
    w = 0;
    while (a_cnt < 4 && w < 60) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (a_cnt < 4) begin
      failures++;
      $display("FAIL midreset_gap_reach phaseA_cycles=%0d want>=4", a_cnt);
    end
    @(posedge clk); #1 reset = 1'b1;
    exp_q.delete(); exp_count = 8'd0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    v = all_outs();
    checks++;
    if (v !== 36'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h want=0", v);
    end
    repeat (60) @(negedge clk);
    checks++;
    if ({obs_q.size() == 0, bus.op_count, bus.busy} !== {1'b1, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_after strobes=%0d count=%0d busy=%b want 0/0/0", obs_q.size(),
               bus.op_count, bus.busy);
    end
    obs_q.delete();
  endtask

  task automatic test_wrap();
    bit   ok;
    rec_t o, e;
    for (int i = 0; i < 256; i++)
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0, 5'd0);
    wait_obs(256, 400, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_timeout ops=%0d want=256", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL wrap_op got=%h want=%h", o, e);
      end
    end
    checks++;
    if (bus.op_count !== 8'd0) begin
      failures++;
      $display("FAIL wrap_count got=%0d want=0", bus.op_count);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_count = 8'd0;
    test_reset();
    test_single();
    test_split(5'd3, 8'hA5, 8'h5A);
    test_back_to_back();
    test_split(5'd20, 8'hC3, 8'h3C);
    test_split(5'd0, 8'h7E, 8'h81);
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_op_issuer.md
# alu_op_issuer

Upstream operand-issue stage for the ALU. It accepts operation requests from a host over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU input pins (`ce`, `inp_valid`, `mode`, `cmd`, `opa`, `opb`, `cin`) cycle by cycle. Operands are presented either together or as a split two-phase delivery with a programmable gap, which exercises the ALU's 16-cycle operand-wait window. After each operation it pulses a strobe that marks when the ALU result is stable for sampling.

## Interface
- `N`, default 8: operand width; matches the ALU `n`.
- `M`, default 4: command width; matches the ALU `m`.
- `DEPTH`, default 4: request FIFO depth; must be a power of 2 and ≥ 2.
- `RESULT_WAIT`, default 2: number of idle cycles after issue before the result is sampled; range 1..7.

- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: host request valid.
- `req_ready` out 1: FIFO can accept a request.
- `req_mode` in 1: 1 = arithmetic, 0 = logical.
- `req_cmd` in M: ALU command.
- `req_opa` in N: operand A.
- `req_opb` in N: operand B.
- `req_cin` in 1: carry in.
- `req_split` in 1: 1 = deliver A and B in separate phases.
- `req_gap` in 5: number of cycles between phase A and phase B (0..31).
- `ce`, `inp_valid[1:0]`, `mode`, `cmd[M]`, `opa[N]`, `opb[N]`, `cin` out: registered ALU drive.
- `sample_strobe` out 1: one-cycle pulse; ALU outputs are valid to sample this cycle.
- `busy` out 1: high when the FSM is not in IDLE or the FIFO is non-empty.
- `op_count` out 8: count of completed operations; wraps from 255 to 0.

## Operation
- FIFO
  - A push occurs when `req_valid && req_ready`.
  - `req_ready = !full`. When the FIFO is full there is no bypass, so a simultaneous pop does not let a push in that cycle.
  - A pop occurs only on the IDLE→ISSUE or IDLE→PHASE_A transition.
- FSM states: IDLE, ISSUE, PHASE_A, GAP, PHASE_B, WAIT.
  - IDLE: if the FIFO is non-empty, pop the head. Go to ISSUE if `split` is 0, otherwise PHASE_A.
  - ISSUE (1 cycle): `ce=1`, `inp_valid=11`, all fields driven from the entry. Next state is WAIT.
  - PHASE_A (1 cycle): `ce=1`, `inp_valid=01`, `opa` driven, `opb=0`. Next state is GAP if `gap>0`, else PHASE_B.
  - GAP (`gap` cycles): hold the PHASE_A drive exactly. A 5-bit down-counter tracks the gap; at terminal count go to PHASE_B.
  - PHASE_B (1 cycle): `ce=1`, `inp_valid=10`, `opa` held, `opb` driven. Next state is WAIT.
  - WAIT (`RESULT_WAIT` cycles): `ce=0`, all other drive holds its last value. `sample_strobe=1` on the final WAIT cycle. Next state is IDLE, and `op_count` increments on exit.
- Outside of reset, `inp_valid` is never driven to 00. Idle drive is always `ce=0` with `inp_valid` held.
- A `req_gap` of 16 or more is legal. The issuer still completes phase B; a resulting ALU `err` is expected and is not reported here.
- `busy = (state != IDLE) || !empty`.

## Timing
- Reset: while `reset` is sampled high at a clock edge:
  - All outputs are forced to 0: `ce`, `inp_valid`, `mode`, `cmd`, `opa`, `opb`, `cin`, `sample_strobe`, `busy`, `op_count`, and `req_ready`.
  - The FIFO pointers clear and the FSM goes to IDLE.
  - `req_ready` goes to 1 on the first clock edge after `reset` deasserts.
- Reset mid-operation aborts immediately. No strobe is produced and no count increment occurs; queued entries are discarded.
- A request accepted at edge E is popped at edge E+1 (IDLE). The first ALU drive with `ce=1` is visible after edge E+2.
- Cycles per operation, counted from the pop: non-split = 1 + `RESULT_WAIT` + 1 (IDLE); split = 1 + `gap` + 1 + `RESULT_WAIT` + 1.
- `sample_strobe` lands exactly `RESULT_WAIT` cycles after the last `ce=1` cycle.

## Test plan
- Reset, then a non-split request: ADD, `mode=1`, `opa=8'h0F`, `opb=8'h01` → one cycle of `ce=1`, `inp_valid=11`; with `RESULT_WAIT=2`, `sample_strobe` pulses 2 cycles later; `op_count=1`.
- Split request with `gap=3`, `opa=8'hA5`, `opb=8'h5A` → 4 consecutive cycles of `inp_valid=01`, `opa=A5`, then 1 cycle of `inp_valid=10`, `opb=5A`, then strobe after `RESULT_WAIT`.
- Push 5 requests back-to-back with `DEPTH=4` → `req_ready` drops after the 4th accept; the 5th is accepted only after the first pop; all 5 issue in order; `op_count=5`.
- Split request with `gap=20` → phase A is held for 21 cycles and phase B is still issued; `sample_strobe` still pulses.
- Assert `reset` for 1 cycle during GAP with 2 entries queued → all outputs are 0 on the next cycle, no strobe, `op_count=0`, `busy=0`.
- Issue 256 non-split operations → `op_count` wraps to 0.
